// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction-fetch stage: PC register, IF/ID register, delay-slot redirects
//
// Owns the program counter and the IF/ID pipeline register. Redirects from
// decode (pc_src/jump_address) follow single-delay-slot semantics: the word
// at pc_f when the redirect is accepted is always delivered. A redirect that
// arrives while instruction memory is not ready is parked in a pending
// register and applied on the next advance.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   stall               hazard hold: freezes PC and IF/ID
//   pc_src              decode jump decision (ignored while stalled)
//   jump_address        redirect target
//   imem_addr           fetch address (= pc_f)
//   imem_data           instruction word, valid when imem_ready = 1
//   imem_ready          instruction memory has the word for imem_addr
//   instr_d             IF/ID instruction
//   pc_plus_four_d      IF/ID PC+4
//   valid_d             IF/ID holds a real instruction (0 = bubble)
//   fetch_misaligned    only with FETCH_ALIGN_CHECK_EN: one-cycle pulse after
//                       a misaligned redirect target was replaced by IVT_BOT
//
// Build option: FETCH_ALIGN_CHECK_EN enables misaligned-target trapping;
// without it, target bits [1:0] are forced to zero.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] jump_address,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus_four_d,
    output logic        valid_d
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

`ifdef FETCH_ALIGN_CHECK_EN
    // Bottom of the interrupt vector table (mips.h IVT_BOT).
    localparam logic [31:0] IVT_BOT = 32'h8000_0180;
`endif

    logic [31:0] pc_f;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic        adv;
    logic        redir;
    logic [31:0] pc_next_seq;
    logic [31:0] tgt_sel;
    logic        tgt_load;

    assign imem_addr   = pc_f;
    assign adv         = imem_ready & ~stall;
    // A bubble in decode can never redirect, so valid_d gates pc_src.
    assign redir       = valid_d & pc_src & ~stall;
    assign pc_next_seq = pc_f + 32'd4;

    // Target chosen on an advance: same-cycle redirect wins over a parked one.
    always_comb begin
        tgt_sel  = redir ? jump_address : pend_tgt;
        tgt_load = adv & (redir | pend_v);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_f           <= RESET_PC;
            instr_d        <= 32'd0;
            pc_plus_four_d <= 32'd0;
            valid_d        <= 1'b0;
            pend_v         <= 1'b0;
            pend_tgt       <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
            // While stalled everything holds, even if memory is not ready.
            if (!stall) begin
                if (imem_ready) begin
                    instr_d        <= imem_data;
                    pc_plus_four_d <= pc_next_seq;
                    valid_d        <= 1'b1;
                end else begin
                    valid_d <= 1'b0;
                end

                if (adv) begin
                    if (tgt_load) begin
                        pend_v <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (tgt_sel[1:0] != 2'b00) begin
                            pc_f             <= IVT_BOT;
                            fetch_misaligned <= 1'b1;
                        end else begin
                            pc_f <= tgt_sel;
                        end
`else
                        pc_f <= tgt_sel & 32'hFFFF_FFFC;
`endif
                    end else begin
                        pc_f <= pc_next_seq;
                    end
                end else if (redir) begin
                    // Memory wait state: the delay slot is still outstanding,
                    // so park the target until the slot is fetched.
                    pend_v   <= 1'b1;
                    pend_tgt <= jump_address;
                end
            end
        end
    end

endmodule
